// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV64M multiply/divide unit in the execute stage.
// Optional `MULDIV_FAST_MUL_EN`: single-cycle multiplier for all multiply ops; divides stay iterative.
module ex_muldiv #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  input  logic            hold,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic is_div;
    logic is_rem;
    logic hi_sel;
    logic neg_q;
    logic neg_r;
    logic word;
  } ctl_t;

  state_t          state_q, state_d;
  ctl_t            ctl_d, ctl_q, spec_ctl;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, opnd_q;

  // Sign/word fix-up. Multiply: {p_hi,p_lo} is the unsigned product.
  // Divide: p_hi is the remainder magnitude, p_lo the quotient magnitude.
  function automatic logic [XLEN-1:0] fixup(input logic [XLEN-1:0] p_hi,
                                            input logic [XLEN-1:0] p_lo,
                                            input ctl_t c);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   v;
    prod = c.neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};
    if (c.is_div) v = c.is_rem ? (c.neg_r ? -p_hi : p_hi) : (c.neg_q ? -p_lo : p_lo);
    else          v = c.hi_sel ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    return c.word ? {{HW{v[HW-1]}}, v[HW-1:0]} : v;
  endfunction

  // Operand decode at accept
  logic            sgn_a, sgn_b, a_neg, b_neg, div0, ovf, special, fast;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_hi, spec_lo, fast_res;

  always_comb begin
    sgn_a   = op[2] ? ~op[0] : (word | (op[1:0] != 2'b11));
    sgn_b   = op[2] ? ~op[0] : (word | ~op[1]);
    a_ext   = word ? {{HW{sgn_a & src1[HW-1]}}, src1[HW-1:0]} : src1;
    b_ext   = word ? {{HW{sgn_b & src2[HW-1]}}, src2[HW-1:0]} : src2;
    a_neg   = sgn_a & a_ext[XLEN-1];
    b_neg   = sgn_b & b_ext[XLEN-1];
    a_mag   = a_neg ? -a_ext : a_ext;
    b_mag   = b_neg ? -b_ext : b_ext;
    min_val = word ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div0    = op[2] & (b_ext == '0);
    ovf     = op[2] & ~op[0] & (a_ext == min_val) & (&b_ext);
    special = div0 | ovf;
    spec_hi = div0 ? a_ext : '0;
    spec_lo = div0 ? '1 : a_ext;

    ctl_d        = '0;
    ctl_d.is_div = op[2];
    ctl_d.is_rem = op[2] & op[1];
    ctl_d.hi_sel = ~op[2] & ~word & (op[1:0] != 2'b00);
    ctl_d.neg_q  = a_neg ^ b_neg;
    ctl_d.neg_r  = a_neg;
    ctl_d.word   = word;

    // special-case results are already signed values
    spec_ctl       = ctl_d;
    spec_ctl.neg_q = 1'b0;
    spec_ctl.neg_r = 1'b0;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_p;
  assign fast     = ~op[2];
  assign fast_p   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
  assign fast_res = fixup(fast_p[2*XLEN-1:XLEN], fast_p[XLEN-1:0], ctl_d);
`else
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif

  // One iteration: shift-add multiply (shift right) or restoring divide (shift left)
  logic [XLEN:0]   sum;
  logic            ge;
  logic [XLEN-1:0] diff, nxt_hi, nxt_lo, run_res;

  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    ge   = {hi_q, lo_q[XLEN-1]} >= {1'b0, opnd_q};
    diff = {hi_q[XLEN-2:0], lo_q[XLEN-1]} - opnd_q;
    if (ctl_q.is_div) begin
      nxt_hi = ge ? diff : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
      nxt_lo = {lo_q[XLEN-2:0], ge};
    end else begin
      nxt_hi = sum[XLEN:1];
      nxt_lo = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign run_res = fixup(nxt_hi, nxt_lo, ctl_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid) state_d = (special | fast) ? DONE : RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    if (!hold) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
    stall = valid & (state_q != DONE);
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // flush leaves result untouched; the rest is reloaded on the next accept
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      ctl_q  <= '0;
      cnt_q  <= '0;
      result <= '0;
    end else if (!flush) begin
      case (state_q)
        IDLE: if (valid) begin
          hi_q   <= '0;
          lo_q   <= op[2] ? a_mag : b_mag;
          opnd_q <= op[2] ? b_mag : a_mag;
          ctl_q  <= ctl_d;
          cnt_q  <= CW'(XLEN - 1);
          if (special)   result <= fixup(spec_hi, spec_lo, spec_ctl);
          else if (fast) result <= fast_res;
        end
        RUN: begin
          hi_q <= nxt_hi;
          lo_q <= nxt_lo;
          if (cnt_q == '0) result <= run_res;
          else             cnt_q  <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
